// File: rtl/serial_shift_tx_if.sv
// Handshake and data bundle for the serial shift transmitter.
// master = the side that supplies words, slave = the transmitter itself.
interface serial_shift_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             En;
   logic             Load;
   logic [WIDTH-1:0] D;
   logic             Q;
   logic             not_Q;
   logic             Valid;
   logic             Ready;
   logic             Done;

   modport master (
      output En, Load, D,
      input  Q, not_Q, Valid, Ready, Done
   );

   modport slave (
      input  En, Load, D,
      output Q, not_Q, Valid, Ready, Done
   );
endinterface

// File: rtl/serial_shift_tx.sv
// Parallel-in, serial-out transmitter: captures a WIDTH-bit word on an
// accepted Load and shifts it out MSB-first on Q/not_Q, framed by Valid
// and a one-cycle Done pulse. All outputs decode from registered state.
module serial_shift_tx #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   serial_shift_tx_if.slave bus
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             q_int;

   // State register: reset wins, otherwise advance only on enabled edges.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
      end else if (bus.En) begin
         state <= state_nx;
      end
   end

   // Next-state logic: Load only matters in IDLE; DONE always returns to IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.Load) state_nx = S_SHIFT;
         S_SHIFT: if (cnt == '0) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Shift register and bit counter: load on accepted word, shift left while bits remain.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (bus.En) begin
         case (state)
            S_IDLE: begin
               if (bus.Load) begin
                  sr  <= bus.D;
                  cnt <= CW'(WIDTH - 1);
               end
            end
            S_SHIFT: begin
               if (cnt != '0) begin
                  sr  <= {sr[WIDTH-2:0], 1'b0};
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from registered state only; not_Q tracks Q unconditionally.
   always_comb begin
      q_int     = 1'b0;
      bus.Ready = 1'b0;
      bus.Valid = 1'b0;
      bus.Done  = 1'b0;
      case (state)
         S_IDLE:  bus.Ready = 1'b1;
         S_SHIFT: begin
            bus.Valid = 1'b1;
            q_int     = sr[WIDTH-1];
         end
         S_DONE:  bus.Done = 1'b1;
         default: ;
      endcase
      bus.Q     = q_int;
      bus.not_Q = ~q_int;
   end

endmodule
